// File: rtl/mul_arbiter.sv
// Round-robin arbiter/sequencer sharing one external WIDTH x WIDTH multiplier.
// Grants one requester, drives registered operands, waits MUL_LATENCY, returns the product.
module mul_arbiter #(
  parameter int NREQ        = 4,
  parameter int WIDTH       = 16,
  parameter int MUL_LATENCY = 0
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic [NREQ-1:0]         iReq,
  input  logic [NREQ*WIDTH-1:0]   iOperandA,
  input  logic [NREQ*WIDTH-1:0]   iOperandB,
  input  logic [NREQ-1:0]         iSigned,
  output logic [NREQ-1:0]         oGrant,
  output logic [NREQ-1:0]         oDone,
  output logic [2*WIDTH-1:0]      oResult,
  output logic                    oBusy,
  output logic [WIDTH-1:0]        oMulA,
  output logic [WIDTH-1:0]        oMulB,
  output logic                    oMulSigned,
  input  logic [2*WIDTH-1:0]      iMulResult
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (MUL_LATENCY > 0) ? $clog2(MUL_LATENCY + 1) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;

  state_e               state_q, state_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [PW-1:0]        win_q, win_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [NREQ-1:0]      grant_q, grant_d;
  logic [NREQ-1:0]      done_q, done_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]     mula_q, mula_d;
  logic [WIDTH-1:0]     mulb_q, mulb_d;
  logic                 msgn_q, msgn_d;

  logic                 found;
  logic [PW-1:0]        win;
  logic [PW-1:0]        idx;

  // First requester found scanning upward from ptr_q, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = PW'((ptr_q + k) % NREQ);
      if (!found && iReq[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    win_d    = win_q;
    cnt_d    = cnt_q;
    grant_d  = '0;
    done_d   = '0;
    result_d = result_q;
    mula_d   = mula_q;
    mulb_d   = mulb_q;
    msgn_d   = msgn_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          win_d   = win;
          mula_d  = iOperandA[win*WIDTH +: WIDTH];
          mulb_d  = iOperandB[win*WIDTH +: WIDTH];
          msgn_d  = iSigned[win];
          cnt_d   = CW'(MUL_LATENCY);
          ptr_d   = PW'((int'(win) + 1) % NREQ);
          grant_d = NREQ'(1) << win;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          result_d = iMulResult;
          done_d   = NREQ'(1) << win_q;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      win_q    <= '0;
      cnt_q    <= '0;
      grant_q  <= '0;
      done_q   <= '0;
      result_q <= '0;
      mula_q   <= '0;
      mulb_q   <= '0;
      msgn_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      win_q    <= win_d;
      cnt_q    <= cnt_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      result_q <= result_d;
      mula_q   <= mula_d;
      mulb_q   <= mulb_d;
      msgn_q   <= msgn_d;
    end
  end

  assign oGrant     = grant_q;
  assign oDone      = done_q;
  assign oResult    = result_q;
  assign oBusy      = (state_q != IDLE);
  assign oMulA      = mula_q;
  assign oMulB      = mulb_q;
  assign oMulSigned = msgn_q;

endmodule
